// File: rtl/chopper_timer_sequencer.sv
// Two-phase chopper timer sequencer.
// Each phase has its own IDLE/ON/OFF FSM. When a phase enters ON it loads a blanking
// timer and a minimum-on timer. After blanking has elapsed, a peak-current trip moves
// the phase to OFF for a fixed off-time. A trip that is accepted while the minimum-on
// timer is still nonzero sets a sticky violation flag.
// Ports (top): clk, resetn (sync, active-low), enable, offtimer_en0/1, config_blank_time[7:0],
//   config_off_time[9:0], config_minimum_on_time[7:0], clear_violation ->
//   blank_timer0/1[7:0], off_timer0/1[9:0], minimum_on_timer0/1[7:0], chop_state0/1[1:0],
//   min_on_violation0/1.

// Single-phase chopper FSM with registered timers and a sticky violation flag.
module chopper_timer_phase (
   input  logic       clk,
   input  logic       resetn,
   input  logic       i_enable,
   input  logic       i_trip,
   input  logic [7:0] i_cfg_blank,
   input  logic [9:0] i_cfg_off,
   input  logic [7:0] i_cfg_min_on,
   input  logic       i_clear_violation,
   output logic [7:0] o_blank_timer,
   output logic [9:0] o_off_timer,
   output logic [7:0] o_min_on_timer,
   output logic [1:0] o_chop_state,
   output logic       o_min_on_violation
);
   localparam int unsigned BLANK_W = 8;
   localparam int unsigned OFF_W   = 10;
   localparam int unsigned MINON_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ON   = 2'b01,
      ST_OFF  = 2'b10
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [BLANK_W-1:0]   r_blank;
   logic [OFF_W-1:0]     r_off;
   logic [MINON_W-1:0]   r_min_on;
   logic                 r_viol;
   logic [BLANK_W-1:0]   w_blank_nxt;
   logic [OFF_W-1:0]     w_off_nxt;
   logic [MINON_W-1:0]   w_min_on_nxt;
   logic                 w_viol_set;
   logic                 w_trip_ok;
   logic                 w_off_done;

   // A trip is only honoured once blanking is over and chopping is enabled
   assign w_trip_ok  = (r_state == ST_ON) && i_trip && (r_blank == '0) && (i_cfg_off != '0);
   // <= 1 rather than == 1 so a zero off-timer can never strand the phase in OFF
   assign w_off_done = (r_off <= OFF_W'(1));

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic; disable overrides everything
   always_comb begin
      w_state_nxt = r_state;
      if (!i_enable) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_ON;
            ST_ON:   if (w_trip_ok)  w_state_nxt = ST_OFF;
            ST_OFF:  if (w_off_done) w_state_nxt = ST_ON;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Next timer values; every ON entry reloads blank/min-on from the live config
   always_comb begin
      w_blank_nxt  = '0;
      w_off_nxt    = '0;
      w_min_on_nxt = '0;
      w_viol_set   = 1'b0;
      if (i_enable) begin
         case (r_state)
            ST_IDLE: begin
               w_blank_nxt  = i_cfg_blank;
               w_min_on_nxt = i_cfg_min_on;
            end
            ST_ON: begin
               if (w_trip_ok) begin
                  // min-on is cleared and blank is already zero on the trip edge
                  w_off_nxt  = i_cfg_off;
                  w_viol_set = (r_min_on != '0);
               end else begin
                  w_blank_nxt  = (r_blank  == '0) ? '0 : r_blank  - BLANK_W'(1);
                  w_min_on_nxt = (r_min_on == '0) ? '0 : r_min_on - MINON_W'(1);
               end
            end
            ST_OFF: begin
               if (w_off_done) begin
                  w_blank_nxt  = i_cfg_blank;
                  w_min_on_nxt = i_cfg_min_on;
               end else begin
                  w_off_nxt = r_off - OFF_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Timer and sticky-flag registers; a set on the same edge as a clear wins
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_blank  <= '0;
         r_off    <= '0;
         r_min_on <= '0;
         r_viol   <= 1'b0;
      end else begin
         r_blank  <= w_blank_nxt;
         r_off    <= w_off_nxt;
         r_min_on <= w_min_on_nxt;
         r_viol   <= w_viol_set | (r_viol & ~i_clear_violation);
      end
   end

   assign o_blank_timer      = r_blank;
   assign o_off_timer        = r_off;
   assign o_min_on_timer     = r_min_on;
   assign o_chop_state       = r_state;
   assign o_min_on_violation = r_viol;
endmodule

// Top: two identical, independent phases sharing clock, reset, enable and configuration.
module chopper_timer_sequencer (
   input  logic       clk,
   input  logic       resetn,
   input  logic       enable,
   input  logic       offtimer_en0,
   input  logic       offtimer_en1,
   input  logic [7:0] config_blank_time,
   input  logic [9:0] config_off_time,
   input  logic [7:0] config_minimum_on_time,
   input  logic       clear_violation,
   output logic [7:0] blank_timer0,
   output logic [7:0] blank_timer1,
   output logic [9:0] off_timer0,
   output logic [9:0] off_timer1,
   output logic [7:0] minimum_on_timer0,
   output logic [7:0] minimum_on_timer1,
   output logic [1:0] chop_state0,
   output logic [1:0] chop_state1,
   output logic       min_on_violation0,
   output logic       min_on_violation1
);
   chopper_timer_phase u_phase0 (
      .clk               (clk),
      .resetn            (resetn),
      .i_enable          (enable),
      .i_trip            (offtimer_en0),
      .i_cfg_blank       (config_blank_time),
      .i_cfg_off         (config_off_time),
      .i_cfg_min_on      (config_minimum_on_time),
      .i_clear_violation (clear_violation),
      .o_blank_timer     (blank_timer0),
      .o_off_timer       (off_timer0),
      .o_min_on_timer    (minimum_on_timer0),
      .o_chop_state      (chop_state0),
      .o_min_on_violation(min_on_violation0)
   );

   chopper_timer_phase u_phase1 (
      .clk               (clk),
      .resetn            (resetn),
      .i_enable          (enable),
      .i_trip            (offtimer_en1),
      .i_cfg_blank       (config_blank_time),
      .i_cfg_off         (config_off_time),
      .i_cfg_min_on      (config_minimum_on_time),
      .i_clear_violation (clear_violation),
      .o_blank_timer     (blank_timer1),
      .o_off_timer       (off_timer1),
      .o_min_on_timer    (minimum_on_timer1),
      .o_chop_state      (chop_state1),
      .o_min_on_violation(min_on_violation1)
   );
endmodule

// File: tb/tb_chopper_timer_sequencer.sv
// Bench for chopper_timer_sequencer: directed scenarios plus randomized traffic, every cycle
// compared against a reference model that tracks each phase as "mode + cycles elapsed
// since the interval started + config latched at the interval start".
module tb_chopper_timer_sequencer;
   logic       clk = 1'b0;
   logic       resetn;
   logic       enable;
   logic       offtimer_en0;
   logic       offtimer_en1;
   logic [7:0] config_blank_time;
   logic [9:0] config_off_time;
   logic [7:0] config_minimum_on_time;
   logic       clear_violation;
   logic [7:0] blank_timer0, blank_timer1;
   logic [9:0] off_timer0, off_timer1;
   logic [7:0] minimum_on_timer0, minimum_on_timer1;
   logic [1:0] chop_state0, chop_state1;
   logic       min_on_violation0, min_on_violation1;

   always #5 clk = ~clk;

   chopper_timer_sequencer dut (
      .clk                   (clk),
      .resetn                (resetn),
      .enable                (enable),
      .offtimer_en0          (offtimer_en0),
      .offtimer_en1          (offtimer_en1),
      .config_blank_time     (config_blank_time),
      .config_off_time       (config_off_time),
      .config_minimum_on_time(config_minimum_on_time),
      .clear_violation       (clear_violation),
      .blank_timer0          (blank_timer0),
      .blank_timer1          (blank_timer1),
      .off_timer0            (off_timer0),
      .off_timer1            (off_timer1),
      .minimum_on_timer0     (minimum_on_timer0),
      .minimum_on_timer1     (minimum_on_timer1),
      .chop_state0           (chop_state0),
      .chop_state1           (chop_state1),
      .min_on_violation0     (min_on_violation0),
      .min_on_violation1     (min_on_violation1)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc_cnt  = 0;

   // Reference model: mode 0 idle, 1 on, 2 off; age = cycles since the interval began
   int m_mode [2];
   int m_age  [2];
   int m_bl   [2];
   int m_mn   [2];
   int m_of   [2];
   int m_viol [2];

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc_cnt, obs, exp);
      end
   endtask

   function automatic int exp_blank(input int p);
      if (m_mode[p] == 1 && m_bl[p] > m_age[p]) return m_bl[p] - m_age[p];
      return 0;
   endfunction

   function automatic int exp_min(input int p);
      if (m_mode[p] == 1 && m_mn[p] > m_age[p]) return m_mn[p] - m_age[p];
      return 0;
   endfunction

   function automatic int exp_off(input int p);
      if (m_mode[p] == 2) return m_of[p] - m_age[p];
      return 0;
   endfunction

   task automatic enter_on(input int p);
      m_mode[p] = 1;
      m_age[p]  = 0;
      m_bl[p]   = int'(config_blank_time);
      m_mn[p]   = int'(config_minimum_on_time);
   endtask

   task automatic model_edge(input int p, input bit trip);
      int  cb;
      int  cm;
      bit  set;
      cb  = exp_blank(p);
      cm  = exp_min(p);
      set = 1'b0;
      if (!resetn) begin
         m_mode[p] = 0;
         m_age[p]  = 0;
         m_viol[p] = 0;
      end else begin
         if (!enable) begin
            m_mode[p] = 0;
            m_age[p]  = 0;
         end else if (m_mode[p] == 0) begin
            enter_on(p);
         end else if (m_mode[p] == 1) begin
            if (trip && cb == 0 && config_off_time != 0) begin
               set       = (cm != 0);
               m_mode[p] = 2;
               m_age[p]  = 0;
               m_of[p]   = int'(config_off_time);
            end else begin
               m_age[p]++;
            end
         end else begin
            if (m_age[p] + 1 >= m_of[p]) enter_on(p);
            else m_age[p]++;
         end
         if (set) m_viol[p] = 1;
         else if (clear_violation) m_viol[p] = 0;
      end
   endtask

   task automatic check_all();
      check("state0", int'(chop_state0),       m_mode[0]);
      check("blank0", int'(blank_timer0),      exp_blank(0));
      check("off0",   int'(off_timer0),        exp_off(0));
      check("minon0", int'(minimum_on_timer0), exp_min(0));
      check("viol0",  int'(min_on_violation0), m_viol[0]);
      check("state1", int'(chop_state1),       m_mode[1]);
      check("blank1", int'(blank_timer1),      exp_blank(1));
      check("off1",   int'(off_timer1),        exp_off(1));
      check("minon1", int'(minimum_on_timer1), exp_min(1));
      check("viol1",  int'(min_on_violation1), m_viol[1]);
   endtask

   // Apply inputs (called at negedge), clock once, update model, check at next negedge
   task automatic cyc(input bit r, input bit e, input bit t0, input bit t1, input bit clr);
      resetn          = r;
      enable          = e;
      offtimer_en0    = t0;
      offtimer_en1    = t1;
      clear_violation = clr;
      @(posedge clk);
      model_edge(0, t0);
      model_edge(1, t1);
      @(negedge clk);
      cyc_cnt++;
      check_all();
   endtask

   task automatic set_cfg(input int bl, input int mn, input int of);
      config_blank_time      = 8'(bl);
      config_minimum_on_time = 8'(mn);
      config_off_time        = 10'(of);
   endtask

   task automatic run_until_mode(input int p, input int mode, input bit t0, input bit t1);
      int n = 0;
      while (m_mode[p] != mode && n < 200) begin
         cyc(1, 1, t0, t1, 0);
         n++;
      end
      check("wait_mode", int'(p == 0 ? chop_state0 : chop_state1), mode);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int p = 0; p < 2; p++) begin
         m_mode[p] = 0; m_age[p] = 0; m_bl[p] = 0; m_mn[p] = 0; m_of[p] = 0; m_viol[p] = 0;
      end
      set_cfg(10, 4, 20);
      cyc(0, 1, 0, 0, 0);
      check("rst_state0", int'(chop_state0), 0);
      check("rst_off1",   int'(off_timer1),  0);

      // Blank masking: early trip ignored, later trip accepted with no violation
      cyc(1, 1, 0, 0, 0);
      check("entry_blank0", int'(blank_timer0), 10);
      repeat (4) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 0);
      check("masked_state0", int'(chop_state0), 1);
      repeat (7) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 0);
      check("trip_off0",  int'(off_timer0),        20);
      check("trip_viol0", int'(min_on_violation0), 0);
      check("indep_state1", int'(chop_state1),     1);

      // Off-time length
      set_cfg(2, 2, 3);
      cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      repeat (2) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 0);
      check("offlen_3", int'(off_timer0), 3);
      cyc(1, 1, 0, 0, 0);
      check("offlen_2", int'(off_timer0), 2);
      cyc(1, 1, 0, 0, 0);
      check("offlen_1", int'(off_timer0), 1);
      cyc(1, 1, 0, 0, 0);
      check("offlen_on",    int'(chop_state0),  1);
      check("offlen_blank", int'(blank_timer0), 2);

      // Min-on violation: set, hold, clear, coincident set+clear
      set_cfg(0, 8, 5);
      cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 0);
      check("viol_set", int'(min_on_violation0), 1);
      repeat (2) cyc(1, 1, 0, 0, 0);
      check("viol_hold", int'(min_on_violation0), 1);
      cyc(1, 1, 0, 0, 1);
      check("viol_clr", int'(min_on_violation0), 0);
      run_until_mode(0, 1, 0, 0);
      cyc(1, 1, 1, 0, 1);
      check("viol_set_wins", int'(min_on_violation0), 1);

      // Enable drop mid-OFF on phase 1
      set_cfg(3, 1, 12);
      cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      run_until_mode(1, 2, 0, 1);
      begin
         int n = 0;
         while (exp_off(1) != 7 && n < 50) begin
            cyc(1, 1, 0, 0, 0);
            n++;
         end
      end
      check("off1_at7", int'(off_timer1), 7);
      cyc(1, 0, 0, 0, 0);
      check("dis_state1", int'(chop_state1),       0);
      check("dis_off1",   int'(off_timer1),        0);
      check("dis_min1",   int'(minimum_on_timer1), 0);
      cyc(1, 1, 0, 0, 0);
      check("reen_state1", int'(chop_state1),  1);
      check("reen_blank1", int'(blank_timer1), 3);

      // Chopping disabled: trips never leave ON
      set_cfg(0, 0, 0);
      repeat (40) cyc(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      check("nochop_state0", int'(chop_state0), 1);
      check("nochop_state1", int'(chop_state1), 1);

      // Reset during OFF with violations set
      set_cfg(0, 8, 9);
      cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 1, 1, 0);
      check("pre_rst_viol0", int'(min_on_violation0), 1);
      cyc(0, 1, 0, 0, 0);
      check("mid_rst_state0", int'(chop_state0),       0);
      check("mid_rst_viol0",  int'(min_on_violation0), 0);
      check("mid_rst_off0",   int'(off_timer0),        0);
      cyc(1, 1, 0, 0, 0);
      check("post_rst_min0", int'(minimum_on_timer0), 8);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            config_blank_time = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                             : 8'($urandom_range(0, 12));
            config_minimum_on_time = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                                  : 8'($urandom_range(0, 15));
            config_off_time = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                                           : 10'($urandom_range(0, 20));
         end
         cyc($urandom_range(0, 199) != 0, $urandom_range(0, 39) != 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 19) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/chopper_timer_sequencer.md
CHOPPER_TIMER_SEQUENCER -- requirements
Module: chopper_timer_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL provide resetn  input  1  synchronous active-low reset, sampled on clk.
REQ-003 The block SHALL provide enable  input  1  driver enable; low forces both phases idle.
REQ-004 The block SHALL provide offtimer_en0, offtimer_en1  input  1 each  peak-current trip request, phase 0 / phase 1.
REQ-005 The block SHALL provide config_blank_time  input  8  blanking length in cycles.
REQ-006 The block SHALL provide config_off_time  input  10  fixed off-time length in cycles; 0 disables chopping.
REQ-007 The block SHALL provide config_minimum_on_time  input  8  minimum on-time in cycles.
REQ-008 The block SHALL provide clear_violation  input  1  single-cycle clear of both violation flags.
REQ-009 The block SHALL provide blank_timer0, blank_timer1  output  8 each  remaining blank cycles.
REQ-010 The block SHALL provide off_timer0, off_timer1  output  10 each  remaining off cycles.
REQ-011 The block SHALL provide minimum_on_timer0, minimum_on_timer1  output  8 each  remaining minimum-on cycles.
REQ-012 The block SHALL provide chop_state0, chop_state1  output  2 each  per-phase state: 00 IDLE, 01 ON, 10 OFF.
REQ-013 The block SHALL provide min_on_violation0, min_on_violation1  output  1 each  sticky flag: trip accepted while minimum-on timer nonzero.

Function
REQ-014 Each phase SHALL run an independent, identical FSM with states IDLE, ON and OFF; phase 0 uses offtimer_en0 and phase 1 uses offtimer_en1.
REQ-015 IDLE SHALL hold all three timers at 0 and transition to ON on the first cycle enable=1.
REQ-016 Every entry into ON SHALL load blank_timer=config_blank_time and minimum_on_timer=config_minimum_on_time on the entry edge, with off_timer=0.
REQ-017 In ON, blank_timer and minimum_on_timer SHALL each decrement by 1 per cycle and saturate at 0, never wrapping.
REQ-018 In ON, offtimer_en SHALL be ignored while blank_timer is nonzero or config_off_time is 0.
REQ-019 In ON with blank_timer=0 and config_off_time nonzero, offtimer_en=1 SHALL load off_timer=config_off_time and move to OFF on the next edge.
REQ-020 When the OFF transition of REQ-019 occurs, minimum_on_timer SHALL be cleared to 0.
REQ-021 If minimum_on_timer is nonzero on the edge that accepts a trip, the block SHALL set that phase's min_on_violation to 1 on the same edge.
REQ-022 In OFF, off_timer SHALL decrement by 1 per cycle and offtimer_en SHALL be ignored.
REQ-023 On the edge where off_timer is 1, the FSM SHALL go to ON per REQ-016, so OFF lasts exactly config_off_time cycles.
REQ-024 Configuration inputs SHALL be sampled only at load edges; changes mid-interval SHALL not affect running timers.
REQ-025 enable=0 SHALL take priority over every other event: on the next edge both FSMs go to IDLE and all timers go to 0.
REQ-026 min_on_violation flags SHALL be cleared only by clear_violation or reset; if set and clear coincide, set SHALL win.
REQ-027 Timer outputs SHALL be registered values; the trip-to-off_timer latency SHALL be 1 cycle.

Reset
REQ-028 When resetn=0 at a clk edge, both FSMs SHALL go to IDLE, all timers to 0, and both violation flags to 0, regardless of other inputs, including mid-OFF.
REQ-029 The first cycle after resetn deasserts with enable=1 SHALL be the IDLE-to-ON edge, loading timers per REQ-016.

Verification
REQ-030 Blank masking: blank=10, min_on=4, off=20, enable=1; pulse offtimer_en0 at ON cycle 5 -> ignored, chop_state0 stays 01; pulse at cycle 12 -> off_timer0=20 next cycle, violation0 stays 0.
REQ-031 Off-time length: off=3, blank=2, min_on=2, trip accepted -> off_timer0 reads 3,2,1 over 3 cycles, then ON with blank_timer0=2.
REQ-032 Min-on violation: blank=0, min_on=8, off=5; trip on the first ON cycle -> min_on_violation0=1 and stays set; clear_violation pulse -> 0; coincident set and clear -> 1.
REQ-033 Enable drop mid-OFF: enable=0 while off_timer1=7 -> next cycle chop_state1=00 and all phase 1 timers=0; enable=1 -> ON with blank loaded.
REQ-034 Independence and disable: trip phase 0 only -> phase 1 unaffected; with config_off_time=0, repeated trips -> both phases stay ON indefinitely.
REQ-035 Reset mid-operation: resetn=0 for one cycle during OFF with violation0 set -> all outputs 0 and state 00 on the following cycle.
